tot_code_assembler: RTL

Downstream stage of the TDC fine encoder in the ETROC2 TOT path. Times a hit with a coarse cycle counter, captures the 6-bit fine code and error flag after the stop edge, and corrects the coarse count using fine bit 5. It then presents a single TOT word on a valid/ready interface to the readout buffer.

---
 rtl/tot_pkg.sv | 21 ++
 rtl/tot_coarse_counter.sv | 36 +++
 rtl/tot_code_assembler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/tot_pkg.sv
// Shared types and constants for the TOT code assembler.
package tot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SETTLE = 2'd2,
    HOLD   = 2'd3
  } tot_state_e;

  localparam int unsigned FINE_W     = 6;
  localparam int unsigned OVF_CODE_W = 32;

  // All-ones word reported on coarse saturation; sliced to TOT width by users.
  localparam logic [OVF_CODE_W-1:0] OVF_CODE = '1;

  function automatic int unsigned tot_w(input int unsigned coarse_w);
    return coarse_w + FINE_W;
  endfunction

endpackage

// File: rtl/tot_coarse_counter.sv
// Saturating coarse cycle counter with synchronous clear and terminal-count flag.
module tot_coarse_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign term_c = &cnt_q;
  assign cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !term_c) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tot_code_assembler.sv
// Times a TOT hit, merges the corrected coarse count with the fine code and
// offers the result on a valid/ready port.
module tot_code_assembler
  import tot_pkg::*;
#(
  parameter int unsigned COARSE_W = 3
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enable,
  input  logic                       hit_start,
  input  logic                       hit_stop,
  input  logic [FINE_W-1:0]          fine_bin,
  input  logic                       fine_err,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [COARSE_W+FINE_W-1:0] tot_code,
  output logic                       tot_err,
  output logic                       tot_ovf,
  output logic                       hit_drop,
  output logic                       busy
);

  localparam int unsigned TOT_W = tot_w(COARSE_W);

  tot_state_e state_q, state_d;

  logic                out_valid_q, out_valid_d;
  logic [TOT_W-1:0]    tot_code_q,  tot_code_d;
  logic                tot_err_q,   tot_err_d;
  logic                tot_ovf_q,   tot_ovf_d;
  logic                hit_drop_q,  hit_drop_d;
  logic                busy_q;

  logic                cnt_clr;
  logic                cnt_en;
  logic [COARSE_W-1:0] cnt;
  logic                cnt_term_c;
  logic                start_ok;
  logic [COARSE_W-1:0] coarse_corr;

  tot_coarse_counter #(.W(COARSE_W)) u_coarse (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .cnt    (cnt),
    .term_c (cnt_term_c)
  );

  assign start_ok = hit_start & enable;

  // Counter holds through SETTLE, so cnt[0] is the parity of the stop cycle.
  always_comb begin
    coarse_corr = cnt;
    if ((fine_bin[FINE_W-1] != cnt[0]) && (cnt != '0)) begin
      coarse_corr = cnt - COARSE_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    out_valid_d = out_valid_q;
    tot_code_d  = tot_code_q;
    tot_err_d   = tot_err_q;
    tot_ovf_d   = tot_ovf_q;
    hit_drop_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          cnt_clr = 1'b1;
          state_d = hit_stop ? SETTLE : COUNT;
        end
      end
      COUNT: begin
        hit_drop_d = hit_start;
        if (!enable) begin
          state_d = IDLE;
        end else if (hit_stop) begin
          state_d = SETTLE;
        end else if (cnt_term_c) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          tot_code_d  = OVF_CODE[TOT_W-1:0];
          tot_err_d   = 1'b0;
          tot_ovf_d   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      SETTLE: begin
        hit_drop_d  = hit_start;
        state_d     = HOLD;
        out_valid_d = 1'b1;
        tot_code_d  = {coarse_corr, fine_bin};
        tot_err_d   = fine_err;
        tot_ovf_d   = 1'b0;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (start_ok) begin
            cnt_clr = 1'b1;
            state_d = COUNT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hit_drop_d = hit_start;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      tot_code_q  <= '0;
      tot_err_q   <= 1'b0;
      tot_ovf_q   <= 1'b0;
      hit_drop_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      tot_code_q  <= tot_code_d;
      tot_err_q   <= tot_err_d;
      tot_ovf_q   <= tot_ovf_d;
      hit_drop_q  <= hit_drop_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign out_valid = out_valid_q;
  assign tot_code  = tot_code_q;
  assign tot_err   = tot_err_q;
  assign tot_ovf   = tot_ovf_q;
  assign hit_drop  = hit_drop_q;
  assign busy      = busy_q;

endmodule
